// File: rtl/mealy_scan_ctrl_pkg.sv
// Shared types and constants for the word-level "01" scan controller.
// The count width is derived from the word width and cannot be overridden.
package mealy_scan_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // A word of 'width' bits holds at most width/2 "01" pairs, counting a chained first bit.
  function automatic int cnt_w(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/mealy_scan_ctrl_if.sv
// Word-in / count-out handshake bundle between the producer/consumer and the controller.
// The master side offers words and takes results; the slave side is the controller.
interface mealy_scan_ctrl_if #(
  parameter int WIDTH = mealy_scan_pkg::WIDTH_DEF
);

  localparam int CNT_W = mealy_scan_pkg::cnt_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_chain;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;

  modport master (
    output in_valid, in_data, in_chain, res_ready,
    input  in_ready, res_valid, res_count
  );

  modport slave (
    input  in_valid, in_data, in_chain, res_ready,
    output in_ready, res_valid, res_count
  );

endinterface

// File: rtl/mealy_scan_ctrl_pattern01_detector.sv
// Single-bit Mealy "01" detector; prev_zero remembers that the last scanned bit was 0.
// History survives idle periods and is only cleared by clr or reset.
module pattern01_detector (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic match
);

  logic prev_zero_q;

  // Detector history: clear wins over a scan step, otherwise hold while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_zero_q <= 1'b0;
    end else if (clr) begin
      prev_zero_q <= 1'b0;
    end else if (en) begin
      prev_zero_q <= ~bit_in;
    end else begin
      prev_zero_q <= prev_zero_q;
    end
  end

  assign match = prev_zero_q & bit_in & en;

endmodule

// File: rtl/mealy_scan_ctrl.sv
// Accepts parallel words, scans them MSB-first through the "01" detector one bit per
// clock and returns the per-word detection count over a second valid/ready handshake.
module mealy_scan_ctrl
  import mealy_scan_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  mealy_scan_ctrl_if.slave       bus,
  output logic                   busy_o,
  output logic                   det_bit_o,
  output logic                   det_match_o
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] res_count_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             busy_q;

  logic accept;
  logic shifting;
  logic det_bit;
  logic det_clr;
  logic det_match;

  assign accept   = bus.in_valid & in_ready_q;
  assign shifting = (state_q == ST_SHIFT);
  assign det_bit  = shifting & shift_q[WIDTH-1];
  assign det_clr  = accept & ~bus.in_chain;

  pattern01_detector u_det (
    .clk    (clk_i),
    .reset  (rst_n_i),
    .clr    (det_clr),
    .en     (shifting),
    .bit_in (det_bit),
    .match  (det_match)
  );

  // Sequencer: state, shift register, bit index, running count and registered handshakes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      res_count_q <= '0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shift_q    <= bus.in_data;
            idx_q      <= '0;
            cnt_q      <= '0;
            state_q    <= ST_SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          shift_q <= {shift_q[WIDTH-2:0], 1'b0};
          idx_q   <= idx_q + 1'b1;
          cnt_q   <= cnt_q + CNT_W'(det_match);
          // The last bit's match is folded straight into the published count.
          if (idx_q == LAST_IDX) begin
            res_count_q <= cnt_q + CNT_W'(det_match);
            res_valid_q <= 1'b1;
            state_q     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_count = res_count_q;
  assign busy_o        = busy_q;
  assign det_bit_o     = det_bit;
  assign det_match_o   = det_match;

endmodule

// File: tb/tb_mealy_scan_ctrl.sv
// Self-checking bench for mealy_scan_ctrl: table of words with expected counts, a result
// scoreboard, per-bit detector checks, plus reset, backpressure and back-to-back sequences.
module tb_mealy_scan_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, det_bit, det_match;

  mealy_scan_ctrl_if #(.WIDTH(W)) bus ();

  mealy_scan_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (bus),
    .busy_o      (busy),
    .det_bit_o   (det_bit),
    .det_match_o (det_match)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic m_pz = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       chain;
    int         gap;
    int         hold;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_count", 32'(bus.res_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_det_bit", 32'(det_bit), 32'd0);
    chk("rst_det_match", 32'(det_match), 32'd0);
  endtask

  task automatic pop_check();
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      chk("res_count", 32'(bus.res_count), 32'(exp_q.pop_front()));
    end
  endtask

  // Called at a negedge while IDLE is expected; returns at a negedge back in IDLE.
  task automatic run_word(input logic [7:0] d, input logic c, input int gap,
                          input int hold, input logic [2:0] exp_cnt);
    logic pz;
    logic eb;
    logic em;
    logic [2:0] mcnt;
    for (int g = 0; g < gap; g++) begin
      chk("gap_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
    end
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_chain  = c;
    bus.res_ready = 1'b0;
    @(posedge clk);
    exp_q.push_back(exp_cnt);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    pz   = c ? m_pz : 1'b0;
    mcnt = 3'd0;
    for (int k = 0; k < W; k++) begin
      eb = d[W-1-k];
      em = pz & eb;
      chk("det_bit", 32'(det_bit), 32'(eb));
      chk("det_match", 32'(det_match), 32'(em));
      chk("shift_busy", 32'(busy), 32'd1);
      chk("shift_in_ready", 32'(bus.in_ready), 32'd0);
      chk("shift_res_valid", 32'(bus.res_valid), 32'd0);
      mcnt = mcnt + 3'(em);
      pz   = ~eb;
      @(negedge clk);
    end
    m_pz = pz;
    chk("model_count", 32'(mcnt), 32'(exp_cnt));
    chk("report_res_valid", 32'(bus.res_valid), 32'd1);
    chk("report_det_bit", 32'(det_bit), 32'd0);
    chk("report_det_match", 32'(det_match), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_res_count", 32'(bus.res_count), 32'(exp_cnt));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("pre_ack_res_valid", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    pop_check();
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_res_valid", 32'(bus.res_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [2:0] model_count(input logic [7:0] d, input logic pz_in,
                                             output logic pz_out);
    logic pz;
    logic [2:0] n;
    pz = pz_in;
    n  = 3'd0;
    for (int k = W - 1; k >= 0; k--) begin
      n  = n + 3'(pz & d[k]);
      pz = ~d[k];
    end
    pz_out = pz;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_acc;
    int t;
    logic [7:0] d;
    logic c;
    logic pz_next;

    vecs[0]  = '{8'h55, 1'b0, 0, 0, 3'd4};
    vecs[1]  = '{8'h00, 1'b0, 0, 0, 3'd0};
    vecs[2]  = '{8'hFF, 1'b0, 0, 0, 3'd0};
    vecs[3]  = '{8'h5A, 1'b0, 0, 0, 3'd3};
    vecs[4]  = '{8'h00, 1'b0, 0, 0, 3'd0};
    vecs[5]  = '{8'h80, 1'b1, 0, 0, 3'd1};
    vecs[6]  = '{8'h00, 1'b0, 0, 0, 3'd0};
    vecs[7]  = '{8'h80, 1'b0, 0, 0, 3'd0};
    vecs[8]  = '{8'h00, 1'b0, 0, 0, 3'd0};
    vecs[9]  = '{8'h80, 1'b1, 10, 0, 3'd1};
    vecs[10] = '{8'h5A, 1'b0, 0, 5, 3'd3};
    vecs[11] = '{8'hAA, 1'b1, 0, 0, 3'd4};
    vecs[12] = '{8'h01, 1'b1, 0, 0, 3'd1};

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_chain  = 1'b0;
    bus.res_ready = 1'b0;

    // Reset held: outputs at reset values and an offered word is not taken.
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_no_accept_busy", 32'(busy), 32'd0);
    chk("rst_no_accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    m_pz = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_word(vecs[i].data, vecs[i].chain, vecs[i].gap, vecs[i].hold, vecs[i].cnt);
    end

    // Reset in the middle of 0x55 while bit_idx = 3 is on the detector.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_chain = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_det_match_before_rst", 32'(det_match), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    m_pz = 1'b0;
    @(negedge clk);
    run_word(8'h80, 1'b1, 0, 0, 3'd0);

    // Back-to-back: in_valid and res_ready held high.
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    last_acc = -1;
    for (int w = 0; w < 6; w++) begin
      t = 0;
      while (t < 12 && !bus.in_ready) begin
        @(negedge clk);
        t++;
      end
      chk("b2b_ready_timeout", 32'(bus.in_ready), 32'd1);
      d = 8'($urandom);
      c = 1'($urandom_range(0, 1));
      bus.in_data  = d;
      bus.in_chain = c;
      if (last_acc >= 0) chk("b2b_interval", 32'(cyc - last_acc), 32'd10);
      last_acc = cyc;
      exp_q.push_back(model_count(d, c ? m_pz : 1'b0, pz_next));
      m_pz = pz_next;
      @(posedge clk);
      @(negedge clk);
      if (w == 5) bus.in_valid = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      t = 0;
      while (t < 15 && !bus.res_valid) begin
        @(negedge clk);
        t++;
      end
      chk("b2b_result_timeout", 32'(bus.res_valid), 32'd1);
      chk("b2b_latency", 32'(t), 32'd8);
      pop_check();
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    chk("b2b_end_idle", 32'(bus.in_ready), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mealy_scan_ctrl.md
# mealy_scan_ctrl

Word-level controller that sequences a single-bit "01" Mealy detector. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first into the detector, one bit per clock. It counts detections per word and returns the count over a second valid/ready handshake. It sits between a word-oriented producer and the serial pattern-detection datapath, and is the only driver of that datapath.

## Interface
- WIDTH, 8: bits per input word; even, ≥ 2
- CNT_W, derived localparam = clog2(WIDTH/2 + 1): count width; not overridable
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- in_valid  input  1  producer offers in_data / in_chain
- in_ready  output  1  controller can accept a word
- in_data  input  WIDTH  word to scan; bit WIDTH-1 is scanned first
- in_chain  input  1  1 = keep the detector history from the previous word's last bit; 0 = clear it
- res_valid  output  1  result available
- res_ready  input  1  consumer takes the result
- res_count  output  CNT_W  number of "01" detections in the word
- busy  output  1  1 in SHIFT or REPORT
- det_bit  output  1  bit presented to the detector this cycle (0 outside SHIFT)
- det_match  output  1  Mealy detector output this cycle (0 outside SHIFT)

## Operation
- **States:** IDLE, SHIFT, REPORT. Reset enters IDLE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: load shift register ← in_data, bit_idx ← 0, count ← 0.
  - If in_chain = 0, clear detector history (prev_zero ← 0) on the same edge.
  - Go to SHIFT.
- **SHIFT**
  - det_bit = shift register MSB.
  - det_match = prev_zero & det_bit. This is combinational from registers only; there is no input-to-output path.
  - Each cycle: prev_zero ← ~det_bit; count += det_match; shift left; bit_idx += 1.
  - After the cycle with bit_idx = WIDTH-1, go to REPORT.
- **REPORT**
  - res_valid = 1; res_count holds the final count, stable until accepted.
  - On res_ready, go to IDLE.
  - in_ready = 0.
- **Detector history (prev_zero):**
  - Reset value 0.
  - Retained across IDLE gaps, so in_chain = 1 links words regardless of idle time.
  - A 1 at the first bit after reset or after a clear never matches.
- **Count range:** at most WIDTH/2 per word, including the chained first-bit match. The counter cannot overflow at CNT_W.
- **Inputs ignored:** in_valid outside IDLE is ignored; in_data is not sampled. res_ready outside REPORT is ignored.
- **Reset mid-operation:** asynchronously returns to IDLE. The partial word is discarded, prev_zero ← 0, and no result is produced.
- **Reset values of outputs:** in_ready = 1 (IDLE), res_valid = 0, res_count = 0, busy = 0, det_bit = 0, det_match = 0. No transfer is accepted while reset is low.

## Timing
- Accept edge T; bits are scanned in cycles T+1 … T+WIDTH.
- res_valid rises in cycle T+WIDTH+1 (latency WIDTH+1).
- With res_ready held high, REPORT lasts 1 cycle. in_ready returns in cycle T+WIDTH+2.
- Max throughput: one word per WIDTH+2 cycles.
- res_count is registered and changes only on the entry to REPORT and on reset.

## Structure
- **Package mealy_scan_pkg:** state enum (IDLE, SHIFT, REPORT), WIDTH default, clog2-based CNT_W function.
- **Sub-module pattern01_detector:**
  - Owns the prev_zero flop.
  - Ports: clk, reset, clr, en, bit_in, match.
  - match = prev_zero & bit_in & en.
  - Async active-low reset.
- **Top (mealy_scan_ctrl):** FSM, shift register, bit_idx, count, handshakes.

## Test plan
- Reset, then word 0x55, chain 0 → det_match high in bit cycles 2, 4, 6, 8; res_valid at T+9; res_count = 4.
- 0x00 and 0xFF, chain 0 → res_count = 0 for both. 0x5A (01011010) → res_count = 3.
- 0x00 then 0x80 with chain 1 → second res_count = 1. Same pair with chain 0 → 0. Insert a 10-cycle idle gap between the words with chain 1 → still 1.
- Hold res_ready low for 5 cycles in REPORT → res_valid and res_count stable, in_ready = 0, a concurrent in_valid is not accepted. Release → IDLE next cycle.
- Assert reset at bit 3 of 0x55 → all outputs at reset values immediately. Next word 0x80 with chain 1 → count 0 (history cleared).
- Back-to-back words with in_valid held high and res_ready high → exactly one accept per 10 cycles (WIDTH = 8), and every count is correct.
